accum_arbiter: RTL and testbench
================================

# accum_arbiter

Round-robin scheduler that shares one split 16+16-bit accumulate datapath among NUM_REQ streaming requesters, such as ROM readers or line parsers. Each requester pushes 32-bit beats with valid/ready and marks its final beat with `last`. The block keeps one private running score and beat count per requester, and emits a tagged result record when that requester's stream ends. It sits between the per-puzzle data sources and the top-level score/report logic.

## Interface
- `NUM_REQ`, default 4: number of requesters, from 2 to 8.
- `DATA_W`, fixed 32: beat and score width.
- `CNT_W`, default 16: per-requester beat counter width.
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  synchronous clear of all accumulators and the in-flight beat; does not affect the output register.
- `req_valid`  in  NUM_REQ  per-requester beat valid.
- `req_data`  in  NUM_REQ*32  beat data; requester i uses bits [32i+31:32i].
- `req_last`  in  NUM_REQ  final beat of requester i's stream.
- `req_ready`  out  NUM_REQ  one-hot grant; a beat transfers when `req_valid[i] & req_ready[i]`.
- `res_valid`  out  1  result record valid.
- `res_ready`  in  1  consumer accepts the result.
- `res_id`  out  clog2(NUM_REQ)  requester index of the result.
- `res_score`  out  32  final score, modulo 2^32.
- `res_count`  out  CNT_W  beats accumulated in the stream, including the last beat, modulo 2^CNT_W.

## Operation
- Arbiter:
  - Rotating priority pointer `ptr`; the search starts at `ptr` and wraps.
  - `req_ready` is one-hot on the first `req_valid` found, or all zero.
  - `req_ready` may depend combinationally on `req_valid`. Requesters must not make `req_valid` depend on `req_ready`.
  - On a transfer from requester i, `ptr` becomes (i+1) mod NUM_REQ. Otherwise `ptr` holds.
- Stall: `req_ready` is all zero while `res_valid` is high, while stage 1 holds a last beat, or while `flush` is high. Rationale: there is a single output register, and a last beat already in flight must have a free slot.
- Stage 1 (capture): registers `s1_valid`, `s1_id`, `s1_data` and `s1_last` from the granted beat.
- Stage 2 (accumulate):
  - When `s1_valid` is high, compute `lo = acc[id][15:0] + data[15:0]` as 17 bits.
  - Compute `hi = acc[id][31:16] + data[31:16] + lo[16]`, and drop bit 16 of `hi`.
  - `sum = {hi[15:0], lo[15:0]}` and `cnt = count[id] + 1`, both wrapping.
  - Not last: write `acc[id] <= sum` and `count[id] <= cnt`.
  - Last: load `res_id`, `res_score <= sum` and `res_count <= cnt`; set `res_valid`; clear `acc[id]` and `count[id]` to 0.
- Output: `res_valid` and its fields hold until `res_valid & res_ready`, then `res_valid` clears on that edge. Fields keep their last value after that.
- Back-to-back beats from the same id need no forwarding, because stage 2 reads and writes `acc[id]` in the same cycle.
- `flush`: on that edge, all `acc` and `count` are set to 0 and `s1_valid` is set to 0; the pending `res_*` is kept and `ptr` is reset to 0. `rst` does the same and also clears `res_valid`.

## Timing
- Reset values: `req_ready` = 0 during `rst`, then follows the arbitration rule. `res_valid` = 0, `res_id` = 0, `res_score` = 0, `res_count` = 0, `ptr` = 0, `s1_valid` = 0, all `acc` and `count` = 0.
- Throughput: one beat per cycle when no stall applies.
- Latency: a beat transferred at edge E is in the accumulator after edge E+1. For a last beat, `res_valid` is high from edge E+1.
- After a last-beat transfer, no grants are made until the result is accepted. Re-arbitration starts in the cycle after the accepting edge, giving a minimum 2-cycle bubble.
- `rst` or `flush` in the same cycle as a transfer: the beat is discarded and is not accumulated.
- `res_ready` asserted while `res_valid` is low has no effect.

## Structure
- Package `accum_pkg` holds `DATA_W`, `HALF_W`=16, and a beat record typedef {id, data, last}.
- Sub-module `split_add32` holds the combinational 16+16 carry-chained adder. It is the same adder the accumulator tops use, so synthesis sees identical structure.
- Arbiter, pipeline registers, accumulator banks and output register stay in `accum_arbiter`. Expected size is about 200 lines.

## Test plan
- Single requester 0 streams 3 beats, 0x10, 0x20 and 0x30 with last on the third, `res_ready` = 1. Required: `res_id`=0, `res_score`=0x60, `res_count`=3, with `res_valid` high 1 cycle after the last transfer.
- Carry across halves: beats 0x0000FFFF then 0x00000001 with last. Required: `res_score`=0x00010000. Wrap case: 0xFFFFFFFF + 0x2 gives `res_score`=0x00000001.
- All 4 requesters valid continuously with no last. Required: grants rotate 0,1,2,3,0, one per cycle, and each `acc` holds its own sum.
- Requesters 1 and 2 both send last in consecutive grants while `res_ready` = 0 for 5 cycles. Required:
  - id 1's result holds stable and no grants occur.
  - After acceptance, id 2's result follows with the correct values.
- `flush` asserted with 2 beats of 0x5 accumulated on id 3. After that, id 3 sends 0x7 with last. Required: `res_score`=0x7, `res_count`=1.
- `rst` asserted while a result is pending and a beat is in stage 1. Required: all outputs return to their reset values next cycle, and no stale result appears.

Source files
------------

// File: rtl/accum_pkg.sv
// Shared widths and the beat record that travels from the arbiter into the
// capture stage of accum_arbiter.
package accum_pkg;
    localparam int DATA_W   = 32;
    localparam int HALF_W   = 16;
    // Wide enough for the largest supported requester count (8).
    localparam int MAX_ID_W = 3;

    typedef struct packed {
        logic [MAX_ID_W-1:0] id;
        logic [DATA_W-1:0]   data;
        logic                last;
    } beat_t;
endpackage

// File: rtl/accum_arbiter_if.sv
// Requester beat bus plus tagged result channel of accum_arbiter.
interface accum_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 16
);
    import accum_pkg::*;
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      res_valid;
    logic                      res_ready;
    logic [ID_W-1:0]           res_id;
    logic [DATA_W-1:0]         res_score;
    logic [CNT_W-1:0]          res_count;

    modport master (
        output req_valid, req_data, req_last, res_ready,
        input  req_ready, res_valid, res_id, res_score, res_count
    );

    modport slave (
        input  req_valid, req_data, req_last, res_ready,
        output req_ready, res_valid, res_id, res_score, res_count
    );
endinterface

// File: rtl/split_add32.sv
// Combinational 32-bit adder built as two 16-bit halves with an explicit
// carry from the low half into the high half; final carry is dropped.
module split_add32
    import accum_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] sum
);
    logic [HALF_W:0]   lo;
    logic [HALF_W-1:0] hi;

    assign lo  = {1'b0, a[HALF_W-1:0]} + {1'b0, b[HALF_W-1:0]};
    assign hi  = a[DATA_W-1:HALF_W] + b[DATA_W-1:HALF_W]
               + {{(HALF_W-1){1'b0}}, lo[HALF_W]};
    assign sum = {hi, lo[HALF_W-1:0]};
endmodule

// File: rtl/accum_arbiter.sv
// Round-robin scheduler feeding a shared accumulate stage that keeps a private
// score/count per requester and emits a tagged result on each stream's last beat.
module accum_arbiter
    import accum_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    accum_arbiter_if.slave  bus
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [ID_W-1:0]    ptr_reg;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_id;
    logic               found;
    logic               stall;
    logic               fire;
    int                 srch_idx;
    beat_t              beat_in;

    beat_t              s1_reg;
    logic               s1_valid_reg;

    logic [DATA_W-1:0]  acc_cur [NUM_REQ];
    logic [CNT_W-1:0]   cnt_cur [NUM_REQ];
    logic [DATA_W-1:0]  acc_sel;
    logic [CNT_W-1:0]   cnt_sel;
    logic [DATA_W-1:0]  sum;
    logic [CNT_W-1:0]   cnt_next;
    logic               s1_fin;

    logic               res_valid_reg;
    logic [ID_W-1:0]    res_id_reg;
    logic [DATA_W-1:0]  res_score_reg;
    logic [CNT_W-1:0]   res_count_reg;

    // A last beat in stage 1 must find the single output register free.
    assign stall = rst | flush | res_valid_reg | (s1_valid_reg & s1_reg.last);
    assign fire  = found & ~stall;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        srch_idx = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            srch_idx = int'(ptr_reg) + k;
            if (srch_idx >= NUM_REQ) srch_idx = srch_idx - NUM_REQ;
            if (!found && bus.req_valid[srch_idx]) begin
                found    = 1'b1;
                grant_id = ID_W'(srch_idx);
            end
        end
        if (found && !stall) grant[grant_id] = 1'b1;
    end

    assign bus.req_ready = grant;

    always_comb begin
        beat_in.id   = MAX_ID_W'(grant_id);
        beat_in.data = bus.req_data[grant_id*DATA_W +: DATA_W];
        beat_in.last = bus.req_last[grant_id];
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            ptr_reg      <= '0;
            s1_valid_reg <= 1'b0;
        end else begin
            s1_valid_reg <= fire;
            if (fire) begin
                ptr_reg <= (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;
                s1_reg  <= beat_in;
            end
        end
    end

    always_comb begin
        acc_sel = '0;
        cnt_sel = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (s1_reg.id == MAX_ID_W'(k)) begin
                acc_sel = acc_cur[k];
                cnt_sel = cnt_cur[k];
            end
        end
    end

    split_add32 u_add (
        .a   (acc_sel),
        .b   (s1_reg.data),
        .sum (sum)
    );

    assign cnt_next = cnt_sel + CNT_W'(1);
    assign s1_fin   = s1_valid_reg & s1_reg.last;

    // Read and write of a bank happen in the same cycle, so back-to-back beats
    // from one requester see the fresh value without forwarding.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_bank
        logic [DATA_W-1:0] acc_reg;
        logic [CNT_W-1:0]  cnt_reg;

        always_ff @(posedge clk) begin
            if (rst || flush) begin
                acc_reg <= '0;
                cnt_reg <= '0;
            end else if (s1_valid_reg && s1_reg.id == MAX_ID_W'(gi)) begin
                acc_reg <= s1_reg.last ? '0 : sum;
                cnt_reg <= s1_reg.last ? '0 : cnt_next;
            end
        end

        assign acc_cur[gi] = acc_reg;
        assign cnt_cur[gi] = cnt_reg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid_reg <= 1'b0;
            res_id_reg    <= '0;
            res_score_reg <= '0;
            res_count_reg <= '0;
        end else if (s1_fin && !flush) begin
            res_valid_reg <= 1'b1;
            res_id_reg    <= s1_reg.id[ID_W-1:0];
            res_score_reg <= sum;
            res_count_reg <= cnt_next;
        end else if (res_valid_reg && bus.res_ready) begin
            res_valid_reg <= 1'b0;
        end
    end

    assign bus.res_valid = res_valid_reg;
    assign bus.res_id    = res_id_reg;
    assign bus.res_score = res_score_reg;
    assign bus.res_count = res_count_reg;
endmodule

// File: tb/tb_accum_arbiter.sv
// Directed bench for accum_arbiter: streams, carries, rotation, back-pressure,
// flush and reset, each checked against hand-computed values.
module tb_accum_arbiter;
    import accum_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int CNT_W   = 16;

    logic clk;
    logic rst;
    logic flush;
    int   n_cmp = 0;
    int   n_err = 0;

    accum_arbiter_if #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) bus ();

    accum_arbiter #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat on requester id, check it is the one granted, transfer it.
    task automatic send(input int id, input logic [31:0] d, input logic last);
        bus.req_valid            = 4'(1 << id);
        bus.req_data[id*32 +: 32] = d;
        bus.req_last             = '0;
        bus.req_last[id]         = last;
        #1;
        check($sformatf("grant_%0d", id), 32'(bus.req_ready), 32'(1 << id));
        tick();
        bus.req_valid = '0;
        bus.req_last  = '0;
    endtask

    task automatic check_result(input string tag, input int id, input logic [31:0] score,
                                input logic [15:0] count);
        check({tag, ".valid"}, 32'(bus.res_valid), 32'd1);
        check({tag, ".id"},    32'(bus.res_id),    32'(id));
        check({tag, ".score"}, bus.res_score,      score);
        check({tag, ".count"}, 32'(bus.res_count), 32'(count));
        $display("result %s: id=%0d score=0x%08h count=%0d", tag, bus.res_id,
                 bus.res_score, bus.res_count);
    endtask

    // Called right after a last-beat transfer with res_ready high.
    task automatic finish_result(input string tag, input int id, input logic [31:0] score,
                                 input logic [15:0] count);
        tick();
        check_result(tag, id, score, count);
        tick();
        check({tag, ".cleared"}, 32'(bus.res_valid), 32'd0);
    endtask

    initial begin
        rst           = 1'b1;
        flush         = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        bus.res_ready = 1'b1;

        // Reset state
        tick();
        bus.req_valid = 4'hF;
        #1;
        check("rst_ready", 32'(bus.req_ready), 32'd0);
        tick();
        check("rst_valid", 32'(bus.res_valid), 32'd0);
        check("rst_id",    32'(bus.res_id),    32'd0);
        check("rst_score", bus.res_score,      32'd0);
        check("rst_count", 32'(bus.res_count), 32'd0);
        bus.req_valid = '0;
        rst = 1'b0;
        tick();

        // Three-beat stream on requester 0
        send(0, 32'h10, 1'b0);
        send(0, 32'h20, 1'b0);
        bus.req_valid = 4'b0001;
        bus.req_data[31:0] = 32'h30;
        bus.req_last = 4'b0001;
        #1;
        check("t1_last_grant", 32'(bus.req_ready), 32'd1);
        tick();
        bus.req_last = '0;
        bus.req_data[31:0] = 32'hDEAD;
        #1;
        check("t1_stall_s1", 32'(bus.req_ready), 32'd0);
        check("t1_not_yet",  32'(bus.res_valid), 32'd0);
        bus.req_valid = '0;
        finish_result("t1", 0, 32'h60, 16'd3);

        // Carry from low half into high half, and wrap past 2^32
        send(0, 32'h0000FFFF, 1'b0);
        send(0, 32'h00000001, 1'b1);
        finish_result("carry", 0, 32'h00010000, 16'd2);
        send(1, 32'hFFFFFFFF, 1'b0);
        send(1, 32'h00000002, 1'b1);
        finish_result("wrap", 1, 32'h00000001, 16'd2);

        // Flush returns the pointer to 0, then all four requesters contend
        flush = 1'b1;
        bus.req_valid = 4'hF;
        #1;
        check("flush_stall", 32'(bus.req_ready), 32'd0);
        tick();
        flush = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) bus.req_data[i*32 +: 32] = 32'((i + 1) * 32'h100);
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("rot_%0d", k), 32'(bus.req_ready), 32'(1 << (k % NUM_REQ)));
            tick();
        end
        bus.req_valid = '0;
        send(0, 32'h1, 1'b1);
        finish_result("rot0", 0, 32'h201, 16'd3);
        send(1, 32'h1, 1'b1);
        finish_result("rot1", 1, 32'h201, 16'd2);
        send(2, 32'h1, 1'b1);
        finish_result("rot2", 2, 32'h301, 16'd2);
        send(3, 32'h1, 1'b1);
        finish_result("rot3", 3, 32'h401, 16'd2);

        // Requesters 1 and 2 both end while the consumer back-pressures
        bus.res_ready = 1'b0;
        bus.req_valid = 4'b0110;
        bus.req_last  = 4'b0110;
        bus.req_data[63:32] = 32'hA;
        bus.req_data[95:64] = 32'hB;
        #1;
        check("bp_grant1", 32'(bus.req_ready), 32'b0010);
        tick();
        bus.req_valid = 4'b0100;
        #1;
        check("bp_stall_s1", 32'(bus.req_ready), 32'd0);
        tick();
        check_result("bp1", 1, 32'hA, 16'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("bp_hold_valid_%0d", i), 32'(bus.res_valid), 32'd1);
            check($sformatf("bp_hold_id_%0d", i),    32'(bus.res_id),    32'd1);
            check($sformatf("bp_hold_score_%0d", i), bus.res_score,      32'hA);
            check($sformatf("bp_hold_ready_%0d", i), 32'(bus.req_ready), 32'd0);
        end
        bus.res_ready = 1'b1;
        tick();
        check("bp_accepted", 32'(bus.res_valid), 32'd0);
        check("bp_grant2",   32'(bus.req_ready), 32'b0100);
        tick();
        bus.req_valid = '0;
        bus.req_last  = '0;
        finish_result("bp2", 2, 32'hB, 16'd1);

        // Flush with two beats of id 3 accumulated / in flight
        send(3, 32'h5, 1'b0);
        send(3, 32'h5, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        send(3, 32'h7, 1'b1);
        finish_result("flush", 3, 32'h7, 16'd1);

        // Reset with a pending result, then with a last beat in stage 1
        bus.res_ready = 1'b0;
        send(2, 32'h50, 1'b0);
        send(0, 32'h11, 1'b1);
        tick();
        check("pre_rst_valid", 32'(bus.res_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst2_valid", 32'(bus.res_valid), 32'd0);
        check("rst2_id",    32'(bus.res_id),    32'd0);
        check("rst2_score", bus.res_score,      32'd0);
        check("rst2_count", 32'(bus.res_count), 32'd0);
        send(1, 32'h40, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst3_valid", 32'(bus.res_valid), 32'd0);
        check("rst3_score", bus.res_score,      32'd0);
        tick();
        check("rst3_no_stale", 32'(bus.res_valid), 32'd0);
        bus.res_ready = 1'b1;
        send(2, 32'h6, 1'b1);
        finish_result("post_rst", 2, 32'h6, 16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
